// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
// Module   : uart_receiver
// Brief    : 8E1 UART receiver with mid-bit sampling, parity/stop checks and
//            one-cycle valid strobe. Optional macro: UART_RX_MAJORITY_VOTE_EN.
// Revision : 1.0
// ============================================================================
module uart_receiver #(
   parameter int CLKS_PER_BIT = 5208,
   parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       serial_input_rx,
   output logic [7:0] data_out,
   output logic       rx_valid,
   output logic       parity_error,
   output logic       frame_error,
   output logic       busy
);

`ifdef UART_RX_MAJORITY_VOTE_EN
   localparam int C_MV = 1;
`else
   localparam int C_MV = 0;
`endif

   // The vote decision lands one cycle after the nominal point; reloading the
   // timer with 1 keeps later sample windows centred on the nominal points.
   localparam logic [15:0] c_start_pt = 16'(HALF_BIT - 1 + C_MV);
   localparam logic [15:0] c_bit_pt   = 16'(CLKS_PER_BIT - 1 + C_MV);
   localparam logic [15:0] c_reload   = 16'(C_MV);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4,
      S_BREAK  = 3'd5
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic        r_sync1;
   logic        r_rx_s;
   logic [15:0] r_timer;
   logic [2:0]  r_idx;
   logic [7:0]  r_shift;
   logic        r_par;
   logic        w_tick;
   logic        w_bit;
   logic        w_active;
   logic        w_stay_active;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync1 <= 1'b1;
         r_rx_s  <= 1'b1;
      end else begin
         r_sync1 <= serial_input_rx;
         r_rx_s  <= r_sync1;
      end
   end

`ifdef UART_RX_MAJORITY_VOTE_EN
   logic [1:0] r_hist;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_hist <= 2'b11;
      end else begin
         r_hist <= {r_hist[0], r_rx_s};
      end
   end

   assign w_bit = (r_hist[1] & r_hist[0]) | (r_hist[1] & r_rx_s) | (r_hist[0] & r_rx_s);
`else
   assign w_bit = r_rx_s;
`endif

   assign w_active      = (r_state == S_START) || (r_state == S_DATA) ||
                          (r_state == S_PARITY) || (r_state == S_STOP);
   assign w_stay_active = (w_state_nxt == S_DATA) || (w_state_nxt == S_PARITY) ||
                          (w_state_nxt == S_STOP);
   assign busy          = (r_state != S_IDLE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_tick      = (r_state == S_START) ? (r_timer == c_start_pt) : (r_timer == c_bit_pt);
      case (r_state)
         S_IDLE:   if (!r_rx_s) w_state_nxt = S_START;
         S_START:  if (w_tick) w_state_nxt = w_bit ? S_IDLE : S_DATA;
         S_DATA:   if (w_tick && (r_idx == 3'd7)) w_state_nxt = S_PARITY;
         S_PARITY: if (w_tick) w_state_nxt = S_STOP;
         S_STOP:   if (w_tick) w_state_nxt = w_bit ? S_IDLE : S_BREAK;
         S_BREAK:  if (r_rx_s) w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_timer      <= '0;
         r_idx        <= '0;
         r_shift      <= '0;
         r_par        <= 1'b0;
         data_out     <= 8'h00;
         rx_valid     <= 1'b0;
         parity_error <= 1'b0;
         frame_error  <= 1'b0;
      end else begin
         rx_valid <= 1'b0;

         if (!w_active) begin
            r_timer <= '0;
         end else if (w_tick) begin
            r_timer <= w_stay_active ? c_reload : 16'd0;
         end else begin
            r_timer <= r_timer + 16'd1;
         end

         if (r_state == S_START) begin
            r_idx <= 3'd0;
         end

         if (w_tick) begin
            case (r_state)
               S_DATA: begin
                  r_shift[r_idx] <= w_bit;
                  r_idx          <= r_idx + 3'd1;
               end
               S_PARITY: r_par <= w_bit;
               S_STOP: begin
                  data_out     <= r_shift;
                  parity_error <= (^r_shift) ^ r_par;
                  frame_error  <= ~w_bit;
                  rx_valid     <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_receiver
// Brief    : Directed self-checking bench for uart_receiver (CLKS_PER_BIT=16).
//            Optional macro: UART_RX_MAJORITY_VOTE_EN.
// Revision : 1.0
// ============================================================================
module tb_uart_receiver;
   localparam int CPB   = 16;
   localparam int FRAME = 11 * CPB;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       serial_input_rx = 1'b1;
   logic [7:0] data_out;
   logic       rx_valid;
   logic       parity_error;
   logic       frame_error;
   logic       busy;

   int         n_cmp = 0;
   int         n_bad = 0;
   int         cyc = 0;
   int         n_valid = 0;
   int         base;
   int         gap;
   int         vcyc[$];
   logic [7:0] vdata[$];

   uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
      .clk             (clk),
      .reset           (reset),
      .serial_input_rx (serial_input_rx),
      .data_out        (data_out),
      .rx_valid        (rx_valid),
      .parity_error    (parity_error),
      .frame_error     (frame_error),
      .busy            (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rx_valid) begin
         n_valid++;
         vcyc.push_back(cyc);
         vdata.push_back(data_out);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic line(input logic v, input int n);
      serial_input_rx = v;
      repeat (n) @(negedge clk);
   endtask

   // g >= 0 inverts the line for that single cycle of the frame
   task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                             input int g, input int len);
      logic [10:0] fb;
      fb = {s, p, d, 1'b0};
      for (int c = 0; c < len; c++) begin
         serial_input_rx = fb[c / CPB] ^ (c == g);
         @(negedge clk);
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_data", data_out, 8'h00);
      chk("rst_valid", rx_valid, 1'b0);
      chk("rst_perr", parity_error, 1'b0);
      chk("rst_ferr", frame_error, 1'b0);
      chk("rst_busy", busy, 1'b0);
      reset = 1'b1;
      line(1'b1, 10);

      base = n_valid;
      send_frame(8'hA5, 1'b0, 1'b1, -1, FRAME);
      line(1'b1, 4);
      chk("a5_count", n_valid - base, 1);
      chk("a5_data", data_out, 8'hA5);
      chk("a5_perr", parity_error, 1'b0);
      chk("a5_ferr", frame_error, 1'b0);
      chk("a5_busy", busy, 1'b0);

      base = n_valid;
      send_frame(8'h01, 1'b0, 1'b1, -1, FRAME);
      line(1'b1, 4);
      chk("badpar_count", n_valid - base, 1);
      chk("badpar_data", data_out, 8'h01);
      chk("badpar_perr", parity_error, 1'b1);
      chk("badpar_ferr", frame_error, 1'b0);
      send_frame(8'h01, 1'b1, 1'b1, -1, FRAME);
      line(1'b1, 4);
      chk("goodpar_count", n_valid - base, 2);
      chk("goodpar_perr", parity_error, 1'b0);

      base = n_valid;
      send_frame(8'h3C, 1'b0, 1'b0, -1, FRAME);
      line(1'b0, 40);
      chk("brk_count", n_valid - base, 1);
      chk("brk_data", data_out, 8'h3C);
      chk("brk_ferr", frame_error, 1'b1);
      chk("brk_perr", parity_error, 1'b0);
      chk("brk_busy_low", busy, 1'b1);
      line(1'b1, 8);
      chk("brk_busy_rel", busy, 1'b0);
      send_frame(8'h55, 1'b0, 1'b1, -1, FRAME);
      line(1'b1, 4);
      chk("post_brk_count", n_valid - base, 2);
      chk("post_brk_data", data_out, 8'h55);
      chk("post_brk_ferr", frame_error, 1'b0);

      base = n_valid;
      line(1'b0, 3);
      chk("glitch_busy", busy, 1'b1);
      line(1'b1, 30);
      chk("glitch_count", n_valid - base, 0);
      chk("glitch_data", data_out, 8'h55);
      chk("glitch_idle", busy, 1'b0);

      base = n_valid;
      send_frame(8'h00, 1'b0, 1'b1, -1, FRAME);
      send_frame(8'hFF, 1'b0, 1'b1, -1, FRAME);
      line(1'b1, 4);
      chk("b2b_count", n_valid - base, 2);
      if (n_valid - base == 2) begin
         chk("b2b_first", vdata[base], 8'h00);
         chk("b2b_second", vdata[base + 1], 8'hFF);
         gap = vcyc[base + 1] - vcyc[base];
         chk("b2b_gap_in_range", (gap >= FRAME - 1) && (gap <= FRAME + 1), 1'b1);
      end
      chk("b2b_perr", parity_error, 1'b0);
      chk("b2b_ferr", frame_error, 1'b0);

      base = n_valid;
      send_frame(8'h77, 1'b0, 1'b1, -1, 5 * CPB + CPB / 2);
      reset = 1'b0;
      serial_input_rx = 1'b1;
      repeat (2) @(negedge clk);
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_data", data_out, 8'h00);
      reset = 1'b1;
      line(1'b1, FRAME);
      chk("midrst_no_valid", n_valid - base, 0);
      send_frame(8'h12, 1'b0, 1'b1, -1, FRAME);
      line(1'b1, 4);
      chk("after_rst_count", n_valid - base, 1);
      chk("after_rst_data", data_out, 8'h12);
      chk("after_rst_perr", parity_error, 1'b0);

`ifdef UART_RX_MAJORITY_VOTE_EN
      // single-cycle inversion exactly at the mid-bit point of data bit 2
      base = n_valid;
      send_frame(8'h5A, 1'b0, 1'b1, 9 + 3 * CPB, FRAME);
      line(1'b1, 4);
      chk("vote_count", n_valid - base, 1);
      chk("vote_data", data_out, 8'h5A);
      chk("vote_perr", parity_error, 1'b0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
